// File: rtl/tlb_pkg.sv
// Shared types and helpers for the TLB translation-table slave.
// Entry layout, AXI response codes and register-word packing live here.
package tlb_pkg;

  localparam int VPN_W = 20;
  localparam int PPN_W = 20;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic WORD_TAG = 1'b0;
  localparam logic WORD_PPN = 1'b1;

  function automatic logic [31:0] tag_word(input tlb_entry_t e);
    tag_word              = 32'd0;
    tag_word[31]          = e.valid;
    tag_word[VPN_W-1:0]   = e.vpn;
  endfunction

  function automatic logic [31:0] ppn_word(input tlb_entry_t e);
    ppn_word              = 32'd0;
    ppn_word[PPN_W-1:0]   = e.ppn;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    apply_strb = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        apply_strb[8*b +: 8] = new_w[8*b +: 8];
      end
    end
  endfunction

endpackage

// File: rtl/tlb_table_slave_if.sv
// AXI4-Lite bus bundle between the tlb_writer master and the table slave.
interface tlb_table_slave_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
endinterface

// File: rtl/tlb_lookup_cam.sv
// Registered VPN->PPN lookup over the whole table; lowest matching index wins.
module tlb_lookup_cam
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  tlb_entry_t [NUM_ENTRIES-1:0]       entries,
  input  logic                               lookup_valid,
  input  logic [VPN_W-1:0]                   lookup_vpn,
  output logic                               lookup_done,
  output logic                               lookup_hit,
  output logic [PPN_W-1:0]                   lookup_ppn
);

  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic [PPN_W-1:0] ppn_q, ppn_d;

  // Scan from the top down so the lowest matching index is the last to land.
  always_comb begin
    done_d = lookup_valid;
    hit_d  = 1'b0;
    ppn_d  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lookup_valid && entries[i].valid && (entries[i].vpn == lookup_vpn)) begin
        hit_d = 1'b1;
        ppn_d = entries[i].ppn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      ppn_q  <= '0;
    end else begin
      done_q <= done_d;
      hit_q  <= hit_d;
      ppn_q  <= ppn_d;
    end
  end

  assign lookup_done = done_q;
  assign lookup_hit  = hit_q;
  assign lookup_ppn  = ppn_q;

endmodule

// File: rtl/tlb_table_slave.sv
// AXI4-Lite slave holding the TLB table written by tlb_writer, with readback
// and a one-cycle registered lookup port. Entry field widths follow tlb_pkg.
module tlb_table_slave
  import tlb_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_ENTRIES        = 16,
  parameter int VPN_W              = tlb_pkg::VPN_W,
  parameter int PPN_W              = tlb_pkg::PPN_W
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  tlb_table_slave_if.slave      s_axi,
  input  logic                  lookup_valid,
  input  logic [VPN_W-1:0]      lookup_vpn,
  output logic                  lookup_done,
  output logic                  lookup_hit,
  output logic [PPN_W-1:0]      lookup_ppn
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [C_S_AXI_ADDR_WIDTH:0] ADDR_LIMIT = (C_S_AXI_ADDR_WIDTH + 1)'(NUM_ENTRIES * 8);

  tlb_entry_t [NUM_ENTRIES-1:0]    table_q, table_d;
  logic                            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [3:0]                      w_strb_q, w_strb_d;
  logic                            awready_q, awready_d, wready_q, wready_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic                            arready_q, arready_d, rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      rresp_q, rresp_d;

  logic              aw_fire_s, w_fire_s, aw_have_s, w_have_s, commit_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
  logic              wr_in_range_s, rd_in_range_s, ar_fire_s;
  logic [31:0]       merged_s;
  logic              unused_bits_s;

  // Write path: AW/W may land in either order; commit as soon as both are in hand.
  always_comb begin
    aw_fire_s     = s_axi.awvalid & awready_q;
    w_fire_s      = s_axi.wvalid & wready_q;
    aw_addr_d     = aw_fire_s ? s_axi.awaddr : aw_addr_q;
    w_data_d      = w_fire_s ? s_axi.wdata : w_data_q;
    w_strb_d      = w_fire_s ? s_axi.wstrb : w_strb_q;
    aw_have_s     = aw_held_q | aw_fire_s;
    w_have_s      = w_held_q | w_fire_s;
    commit_s      = aw_have_s & w_have_s;
    aw_held_d     = aw_have_s & ~commit_s;
    w_held_d      = w_have_s & ~commit_s;
    wr_idx_s      = aw_addr_d[IDX_W+2:3];
    wr_in_range_s = ({1'b0, aw_addr_d} < ADDR_LIMIT);
    merged_s      = 32'd0;
    table_d       = table_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    if (commit_s) begin
      bvalid_d = 1'b1;
      if (wr_in_range_s) begin
        bresp_d = RESP_OKAY;
        if (aw_addr_d[2] == WORD_TAG) begin
          merged_s                 = apply_strb(tag_word(table_q[wr_idx_s]), w_data_d, w_strb_d);
          table_d[wr_idx_s].valid  = merged_s[31];
          table_d[wr_idx_s].vpn    = merged_s[VPN_W-1:0];
        end else begin
          merged_s                 = apply_strb(ppn_word(table_q[wr_idx_s]), w_data_d, w_strb_d);
          table_d[wr_idx_s].ppn    = merged_s[PPN_W-1:0];
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q & s_axi.bready) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end else begin
      bvalid_d = bvalid_q;
    end
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Read path samples the pre-write table, so a colliding write shows its old value.
  always_comb begin
    ar_fire_s     = s_axi.arvalid & arready_q;
    rd_idx_s      = s_axi.araddr[IDX_W+2:3];
    rd_in_range_s = ({1'b0, s_axi.araddr} < ADDR_LIMIT);
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    if (ar_fire_s) begin
      rvalid_d = 1'b1;
      if (!rd_in_range_s) begin
        rdata_d = 32'd0;
        rresp_d = RESP_SLVERR;
      end else if (s_axi.araddr[2] == WORD_TAG) begin
        rdata_d = tag_word(table_q[rd_idx_s]);
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = ppn_word(table_q[rd_idx_s]);
        rresp_d = RESP_OKAY;
      end
    end else if (rvalid_q & s_axi.rready) begin
      rvalid_d = 1'b0;
      rdata_d  = 32'd0;
      rresp_d  = RESP_OKAY;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      table_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= 4'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      table_q   <= table_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign unused_bits_s = ^{aw_addr_d[1:0], s_axi.araddr[1:0], merged_s};

  tlb_lookup_cam #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_cam (
    .clk          (ACLK),
    .rst          (ARESET),
    .entries      (table_q),
    .lookup_valid (lookup_valid),
    .lookup_vpn   (lookup_vpn),
    .lookup_done  (lookup_done),
    .lookup_hit   (lookup_hit),
    .lookup_ppn   (lookup_ppn)
  );

endmodule
